// File: rtl/timer_capture.sv
// Multi-channel input capture: shared free-running timebase, per-channel edge timestamping,
// round-robin delivery over a valid/ready stream. Define TIMER_CAPTURE_SYNC_EN for a 2-flop input synchronizer.

module timer_capture #(
  parameter  int TIMER_BITWIDTH = 32,
  parameter  int NB_CAPTURES    = 10,
  localparam int CH_W           = (NB_CAPTURES > 1) ? $clog2(NB_CAPTURES) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_an_i,
  input  logic                      counter_clr_i,
  output logic [TIMER_BITWIDTH-1:0] counter_o,
  input  logic [NB_CAPTURES-1:0]    event_i,
  input  logic [NB_CAPTURES-1:0]    capture_en_i,
  input  logic [NB_CAPTURES-1:0]    edge_sel_i,
  output logic                      cap_valid_o,
  input  logic                      cap_ready_i,
  output logic [CH_W-1:0]           cap_channel_o,
  output logic [TIMER_BITWIDTH-1:0] cap_value_o,
  output logic                      cap_overrun_o
);

  logic [TIMER_BITWIDTH-1:0] r_counter;
  logic [NB_CAPTURES-1:0]    w_d;
  logic [NB_CAPTURES-1:0]    r_hist;
  logic [NB_CAPTURES-1:0]    w_cap;
  logic [NB_CAPTURES-1:0]    r_pend;
  logic [NB_CAPTURES-1:0]    r_ovr;
  logic [NB_CAPTURES-1:0]    w_drain;
  logic [TIMER_BITWIDTH-1:0] r_val [NB_CAPTURES];
  logic                      r_valid;
  logic [CH_W-1:0]           r_channel;
  logic [TIMER_BITWIDTH-1:0] r_value;
  logic                      r_overrun;
  logic [CH_W-1:0]           r_start;
  logic [CH_W-1:0]           w_sel;
  logic                      w_found;
  logic                      w_load;
  int                        w_idx;

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i)          r_counter <= '0;
    else if (counter_clr_i) r_counter <= '0;
    else                    r_counter <= r_counter + 1'b1;
  end

`ifdef TIMER_CAPTURE_SYNC_EN
  logic [NB_CAPTURES-1:0] r_sync1;
  logic [NB_CAPTURES-1:0] r_sync2;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= event_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_d = r_sync2;
`else
  assign w_d = event_i;
`endif

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) r_hist <= '0;
    else           r_hist <= w_d;
  end

  assign w_cap = ((edge_sel_i & ~w_d & r_hist) | (~edge_sel_i & w_d & ~r_hist)) & capture_en_i;

  // Round-robin: first pending slot at or after r_start, wrapping modulo NB_CAPTURES.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 0; k < NB_CAPTURES; k++) begin
      w_idx = int'(r_start) + k;
      if (w_idx >= NB_CAPTURES) w_idx = w_idx - NB_CAPTURES;
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(w_idx);
      end
    end
  end

  assign w_load = (!r_valid || cap_ready_i) && w_found;

  always_comb begin
    w_drain = '0;
    if (w_load) w_drain[w_sel] = 1'b1;
  end

  // A capture landing on a slot that is drained at the same edge refills it cleanly.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      r_pend <= '0;
      r_ovr  <= '0;
      // NOTE: the slot array is flops, not RAM, so it takes the async reset with everything else.
      for (int i = 0; i < NB_CAPTURES; i++) r_val[i] <= '0;
    end else begin
      for (int i = 0; i < NB_CAPTURES; i++) begin
        if (w_cap[i]) begin
          if (!r_pend[i] || w_drain[i]) begin
            r_val[i]  <= r_counter;
            r_pend[i] <= 1'b1;
            r_ovr[i]  <= 1'b0;
          end else begin
            r_ovr[i]  <= 1'b1;
          end
        end else if (w_drain[i]) begin
          r_pend[i] <= 1'b0;
          r_ovr[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      r_valid   <= 1'b0;
      r_channel <= '0;
      r_value   <= '0;
      r_overrun <= 1'b0;
      r_start   <= '0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_channel <= w_sel;
      r_value   <= r_val[w_sel];
      r_overrun <= r_ovr[w_sel];
      r_start   <= (w_sel == CH_W'(NB_CAPTURES - 1)) ? '0 : w_sel + 1'b1;
    end else if (cap_ready_i) begin
      r_valid   <= 1'b0;
    end
  end

  assign counter_o     = r_counter;
  assign cap_valid_o   = r_valid;
  assign cap_channel_o = r_channel;
  assign cap_value_o   = r_value;
  assign cap_overrun_o = r_overrun;

endmodule

// File: tb/tb_timer_capture.sv
// Self-checking bench for timer_capture: directed scenarios with hand-derived expectations,
// then randomized traffic compared cycle by cycle against a transaction-level model.

module tb_timer_capture;

  localparam int TW = 8;
  localparam int NB = 10;
  localparam int CW = 4;
`ifdef TIMER_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_an_i = 1'b0;
  logic          counter_clr_i = 1'b0;
  logic [TW-1:0] counter_o;
  logic [NB-1:0] event_i = '0;
  logic [NB-1:0] capture_en_i = '1;
  logic [NB-1:0] edge_sel_i = '0;
  logic          cap_valid_o;
  logic          cap_ready_i = 1'b1;
  logic [CW-1:0] cap_channel_o;
  logic [TW-1:0] cap_value_o;
  logic          cap_overrun_o;

  int n_err = 0;
  int n_chk = 0;

  timer_capture #(.TIMER_BITWIDTH(TW), .NB_CAPTURES(NB)) dut (
    .clk_i         (clk_i),
    .rst_an_i      (rst_an_i),
    .counter_clr_i (counter_clr_i),
    .counter_o     (counter_o),
    .event_i       (event_i),
    .capture_en_i  (capture_en_i),
    .edge_sel_i    (edge_sel_i),
    .cap_valid_o   (cap_valid_o),
    .cap_ready_i   (cap_ready_i),
    .cap_channel_o (cap_channel_o),
    .cap_value_o   (cap_value_o),
    .cap_overrun_o (cap_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  logic [TW-1:0] m_cnt;
  logic [NB-1:0] m_pend;
  logic [NB-1:0] m_ovr;
  logic [TW-1:0] m_val [NB];
  logic          m_valid;
  int            m_ch;
  logic [TW-1:0] m_value;
  logic          m_ovf;
  int            m_start;
  logic [NB-1:0] ev_past [1:3];

  task automatic model_reset();
    m_cnt = '0; m_pend = '0; m_ovr = '0;
    for (int i = 0; i < NB; i++) m_val[i] = '0;
    m_valid = 1'b0; m_ch = 0; m_value = '0; m_ovf = 1'b0; m_start = 0;
    for (int i = 1; i <= 3; i++) ev_past[i] = '0;
  endtask

  // One clock edge: deliver first (frees a slot), then record new captures, then tick the timebase.
  task automatic model_step();
    logic [NB-1:0] d_now, d_prev, rise, fall, cap;
    int pick;
    d_now  = (LAT == 2) ? ev_past[2] : event_i;
    d_prev = (LAT == 2) ? ev_past[3] : ev_past[1];
    rise   = d_now & ~d_prev;
    fall   = ~d_now & d_prev;
    cap    = ((edge_sel_i & fall) | (~edge_sel_i & rise)) & capture_en_i;
    pick   = -1;
    if (!m_valid || cap_ready_i)
      for (int k = 0; k < NB; k++)
        if (pick < 0 && m_pend[(m_start + k) % NB]) pick = (m_start + k) % NB;
    if (pick >= 0) begin
      m_valid = 1'b1; m_ch = pick; m_value = m_val[pick]; m_ovf = m_ovr[pick];
      m_start = (pick + 1) % NB;
      m_pend[pick] = 1'b0; m_ovr[pick] = 1'b0;
    end else if (cap_ready_i) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NB; i++)
      if (cap[i]) begin
        if (!m_pend[i]) begin m_val[i] = m_cnt; m_pend[i] = 1'b1; m_ovr[i] = 1'b0; end
        else m_ovr[i] = 1'b1;
      end
    m_cnt = counter_clr_i ? '0 : m_cnt + 1'b1;
    ev_past[3] = ev_past[2]; ev_past[2] = ev_past[1]; ev_past[1] = event_i;
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_an_i);
      if (!rst_an_i) model_reset();
      else           model_step();
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    rst_an_i = 1'b0; event_i = '0; counter_clr_i = 1'b0;
    tick(); tick();
    rst_an_i = 1'b1;
  endtask

  task automatic wait_cnt(input logic [TW-1:0] target);
    int n = 0;
    while (m_cnt !== target && n < 600) begin tick(); n++; end
    if (m_cnt !== target) begin
      n_chk++; n_err++;
      $display("FAIL wait_cnt: timebase never reached %0d (at %0d)", target, m_cnt);
    end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (counter_o !== '0 || cap_valid_o !== 1'b0 || cap_channel_o !== '0 ||
        cap_value_o !== '0 || cap_overrun_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: cnt=%0d v=%0b ch=%0d val=%0d ovr=%0b expected all 0",
               counter_o, cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o);
    end
  endtask

  task automatic test_timebase();
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if (counter_o !== TW'(i) || cap_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL timebase_count: cnt=%0d v=%0b expected cnt=%0d v=0", counter_o, cap_valid_o, i);
      end
    end
    for (int i = 12; i < 100; i++) tick();
    counter_clr_i = 1'b1;
    tick();
    counter_clr_i = 1'b0;
    n_chk++;
    if (counter_o !== '0) begin
      n_err++; $display("FAIL timebase_clear: cnt=%0d expected 0", counter_o);
    end
    tick();
    n_chk++;
    if (counter_o !== TW'(1)) begin
      n_err++; $display("FAIL timebase_after_clear: cnt=%0d expected 1", counter_o);
    end
  endtask

  task automatic test_single_capture();
    bit quiet = 1'b1;
    cap_ready_i = 1'b1;
    wait_cnt(TW'(50));
    event_i[3] = 1'b1;
    repeat (LAT + 1) begin tick(); if (cap_valid_o !== 1'b0) quiet = 1'b0; end
    tick();
    n_chk++;
    if (!quiet || cap_valid_o !== 1'b1 || cap_channel_o !== CW'(3) ||
        cap_value_o !== TW'(50 + LAT) || cap_overrun_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_capture: early=%0b v=%0b ch=%0d val=%0d ovr=%0b expected v=1 ch=3 val=%0d ovr=0",
               !quiet, cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o, 50 + LAT);
    end
    tick();
    n_chk++;
    if (cap_valid_o !== 1'b0) begin
      n_err++; $display("FAIL single_one_cycle: v=%0b expected 0", cap_valid_o);
    end
    event_i[3] = 1'b0;
    quiet = 1'b1;
    repeat (LAT + 4) begin tick(); if (cap_valid_o !== 1'b0) quiet = 1'b0; end
    n_chk++;
    if (!quiet) begin
      n_err++; $display("FAIL falling_ignored: valid seen=1 expected 0");
    end
  endtask

  task automatic test_simultaneous();
    int chans [3] = '{0, 4, 9};
    logic [TW-1:0] c;
    apply_reset();
    cap_ready_i = 1'b1;
    tick(); tick(); tick();
    c = m_cnt;
    event_i[0] = 1'b1; event_i[4] = 1'b1; event_i[9] = 1'b1;
    repeat (LAT + 1) tick();
    for (int j = 0; j < 3; j++) begin
      tick();
      n_chk++;
      if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(chans[j]) ||
          cap_value_o !== TW'(c + LAT) || cap_overrun_o !== 1'b0) begin
        n_err++;
        $display("FAIL simultaneous_%0d: v=%0b ch=%0d val=%0d ovr=%0b expected v=1 ch=%0d val=%0d ovr=0",
                 j, cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o, chans[j], c + LAT);
      end
    end
    tick();
    n_chk++;
    if (cap_valid_o !== 1'b0) begin
      n_err++; $display("FAIL simultaneous_drained: v=%0b expected 0", cap_valid_o);
    end
    event_i = '0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_overrun();
    logic [TW-1:0] c7, c0, c1;
    apply_reset();
    cap_ready_i = 1'b0;
    c7 = m_cnt;
    event_i[7] = 1'b1;
    repeat (LAT + 2) tick();
    event_i[7] = 1'b0;
    c0 = m_cnt;
    for (int p = 0; p < 3; p++) begin
      event_i[2] = 1'b1; tick();
      event_i[2] = 1'b0; tick();
    end
    repeat (LAT + 2) tick();
    n_chk++;
    if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(7) || cap_value_o !== TW'(c7 + LAT) ||
        cap_overrun_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_stable: v=%0b ch=%0d val=%0d ovr=%0b expected v=1 ch=7 val=%0d ovr=0",
               cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o, c7 + LAT);
    end
    cap_ready_i = 1'b1;
    tick();
    n_chk++;
    if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(2) || cap_value_o !== TW'(c0 + LAT) ||
        cap_overrun_o !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_oldest: v=%0b ch=%0d val=%0d ovr=%0b expected v=1 ch=2 val=%0d ovr=1",
               cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o, c0 + LAT);
    end
    tick();
    c1 = m_cnt;
    event_i[2] = 1'b1;
    repeat (LAT + 2) tick();
    n_chk++;
    if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(2) || cap_value_o !== TW'(c1 + LAT) ||
        cap_overrun_o !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_cleared: v=%0b ch=%0d val=%0d ovr=%0b expected v=1 ch=2 val=%0d ovr=0",
               cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o, c1 + LAT);
    end
    event_i[2] = 1'b0;
    tick();
  endtask

  task automatic test_edge_sel();
    bit quiet = 1'b1;
    logic [TW-1:0] c;
    cap_ready_i = 1'b1;
    edge_sel_i[5] = 1'b1;
    tick();
    event_i[5] = 1'b1;
    repeat (LAT + 4) begin tick(); if (cap_valid_o !== 1'b0) quiet = 1'b0; end
    n_chk++;
    if (!quiet) begin n_err++; $display("FAIL edge_sel_rise_ignored: valid seen=1 expected 0"); end
    c = m_cnt;
    event_i[5] = 1'b0;
    repeat (LAT + 2) tick();
    n_chk++;
    if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(5) || cap_value_o !== TW'(c + LAT)) begin
      n_err++;
      $display("FAIL edge_sel_fall: v=%0b ch=%0d val=%0d expected v=1 ch=5 val=%0d",
               cap_valid_o, cap_channel_o, cap_value_o, c + LAT);
    end
    tick();
    capture_en_i[5] = 1'b0;
    event_i[5] = 1'b1; tick(); tick();
    event_i[5] = 1'b0;
    quiet = 1'b1;
    repeat (LAT + 4) begin tick(); if (cap_valid_o !== 1'b0) quiet = 1'b0; end
    n_chk++;
    if (!quiet) begin n_err++; $display("FAIL disabled_channel: valid seen=1 expected 0"); end
    capture_en_i[5] = 1'b1;
    edge_sel_i[5] = 1'b0;
  endtask

  task automatic test_boundaries();
    cap_ready_i = 1'b1;
    wait_cnt(TW'(255 - LAT));
    event_i[0] = 1'b1;
    repeat (LAT + 2) tick();
    n_chk++;
    if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(0) || cap_value_o !== 8'hFF) begin
      n_err++;
      $display("FAIL wrap_capture: v=%0b ch=%0d val=%0d expected v=1 ch=0 val=255",
               cap_valid_o, cap_channel_o, cap_value_o);
    end
    event_i[0] = 1'b0;
    tick();
    wait_cnt(TW'(20));
    event_i[1] = 1'b1;
    repeat (LAT) tick();
    counter_clr_i = 1'b1;
    tick();
    counter_clr_i = 1'b0;
    n_chk++;
    if (counter_o !== '0) begin
      n_err++; $display("FAIL clear_with_capture_cnt: cnt=%0d expected 0", counter_o);
    end
    tick();
    n_chk++;
    if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(1) || cap_value_o !== TW'(20 + LAT)) begin
      n_err++;
      $display("FAIL clear_preclear_value: v=%0b ch=%0d val=%0d expected v=1 ch=1 val=%0d",
               cap_valid_o, cap_channel_o, cap_value_o, 20 + LAT);
    end
    event_i[1] = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bit quiet = 1'b1;
    apply_reset();
    cap_ready_i = 1'b0;
    event_i[1] = 1'b1; event_i[6] = 1'b1;
    repeat (LAT + 2) tick();
    n_chk++;
    if (cap_valid_o !== 1'b1 || cap_channel_o !== CW'(1)) begin
      n_err++; $display("FAIL pre_reset_valid: v=%0b ch=%0d expected v=1 ch=1", cap_valid_o, cap_channel_o);
    end
    #2 rst_an_i = 1'b0;
    #1;
    n_chk++;
    if (counter_o !== '0 || cap_valid_o !== 1'b0 || cap_channel_o !== '0 ||
        cap_value_o !== '0 || cap_overrun_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: cnt=%0d v=%0b ch=%0d val=%0d ovr=%0b expected all 0",
               counter_o, cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o);
    end
    event_i = '0;
    tick(); tick();
    rst_an_i = 1'b1;
    cap_ready_i = 1'b1;
    repeat (10) begin tick(); if (cap_valid_o !== 1'b0) quiet = 1'b0; end
    n_chk++;
    if (!quiet) begin n_err++; $display("FAIL reset_discards: valid seen=1 expected 0"); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      n_chk++;
      if (counter_o !== m_cnt) begin
        n_err++; $display("FAIL rand_counter@%0d: cnt=%0d expected %0d", cyc, counter_o, m_cnt);
      end
      n_chk++;
      if (cap_valid_o !== m_valid ||
          (m_valid && (cap_channel_o !== CW'(m_ch) || cap_value_o !== m_value ||
                       cap_overrun_o !== m_ovf))) begin
        n_err++;
        $display("FAIL rand_stream@%0d: v=%0b ch=%0d val=%0d ovr=%0b expected v=%0b ch=%0d val=%0d ovr=%0b",
                 cyc, cap_valid_o, cap_channel_o, cap_value_o, cap_overrun_o,
                 m_valid, m_ch, m_value, m_ovf);
      end
      event_i       = event_i ^ NB'($urandom & $urandom);
      cap_ready_i   = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      counter_clr_i = ($urandom_range(0, 96) == 0);
      if (cyc % 100 == 0) capture_en_i = NB'($urandom | $urandom);
      if (cyc % 150 == 0) edge_sel_i   = NB'($urandom);
    end
    counter_clr_i = 1'b0;
    event_i = '0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_timebase();
    test_single_capture();
    test_simultaneous();
    test_overrun();
    test_edge_sel();
    test_boundaries();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_capture.md
# timer_capture

Multi-channel input-capture unit for the timer subsystem: it owns the shared free-running timebase, timestamps edges on external event inputs, and delivers timestamps to the host side over a valid/ready stream. It is the inbound counterpart of the compare/alarm path. Its `counter_o` feeds the alarm comparators, and its captures report when external events occurred on that same timebase.

## Interface
- `TIMER_BITWIDTH`, 32: width of the timebase and of captured values.
- `NB_CAPTURES`, 10: number of event channels.
- `CH_W`, derived, max(1, clog2(NB_CAPTURES)): channel index width. Not user-set.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_an_i`, in, 1: reset, asynchronous, active-low.
- `counter_clr_i`, in, 1: synchronous clear of the timebase.
- `counter_o`, out, TIMER_BITWIDTH: free-running timebase.
- `event_i`, in, NB_CAPTURES: external event lines.
- `capture_en_i`, in, NB_CAPTURES: per-channel capture enable.
- `edge_sel_i`, in, NB_CAPTURES: per-channel edge select. 0 = rising, 1 = falling.
- `cap_valid_o`, out, 1: output capture valid.
- `cap_ready_i`, in, 1: consumer ready.
- `cap_channel_o`, out, CH_W: channel of the presented capture.
- `cap_value_o`, out, TIMER_BITWIDTH: timestamp of the presented capture.
- `cap_overrun_o`, out, 1: at least one edge on this channel was dropped since its previous delivered capture.

## Operation
- **Timebase**
  - `counter_o` increments by 1 every cycle and wraps from 2^W−1 to 0.
  - When `counter_clr_i` = 1, `counter_o` loads 0 at the next edge. Clear has priority over increment.
- **Edge detect, per channel**
  - Detection signal `d` (see Configuration). History flop `h <= d` updates every cycle regardless of enable.
  - Rising edge = `d & ~h`. Falling edge = `~d & h`, chosen by `edge_sel_i`.
- **Capture slot, per channel**
  - Each slot holds {pending, value, overrun}.
  - On a detected edge with `capture_en_i[i]` = 1:
    - If the slot is empty, or is being drained this cycle: load value = current `counter_o` and set pending.
    - Otherwise, keep the old value (oldest wins) and set the sticky overrun.
- **Effect of `capture_en_i` = 0**
  - Edges are ignored.
  - An already-pending slot is kept and still delivered.
- **Output stage**
  - One register holding {valid, channel, value, overrun}.
  - It loads when (`!cap_valid_o || cap_ready_i`) and any slot is pending.
  - Selection is round-robin, starting at the channel after the last loaded channel.
  - The loaded slot's pending and overrun bits clear at that edge, unless a new capture lands in the same slot at the same edge; in that case pending stays set and overrun stays clear.
  - While `cap_valid_o` = 1 and `cap_ready_i` = 0, all output fields stay stable.
- **Throughput:** one capture per cycle, back-to-back.
- **Reset values:** all zero, including `counter_o`, `cap_valid_o`, `cap_channel_o`, `cap_value_o`, `cap_overrun_o`, all slots and the history flops. Reset asserted mid-stream discards all pending captures immediately.

## Timing
- Event sampled at edge k (the first edge that sees the new level):
  - With synchronizer: edge detected in the cycle after edge k+1, and the slot loads at edge k+2 with the `counter_o` value of that cycle.
  - Without synchronizer: the slot loads at edge k with the `counter_o` value before edge k.
- Slot to output register: 1 cycle when the output stage is free.
- Capture in the same cycle as `counter_clr_i`: records the pre-clear value.
- Capture at the wrap cycle: records 2^W−1.
- Simultaneous edges on several channels: all are captured in the same cycle, then drained round-robin.

## Configuration
- `TIMER_CAPTURE_SYNC_EN`
  - Defined: `d` is the output of a 2-flop synchronizer on `event_i`, so asynchronous events are safe.
  - Undefined: `d = event_i` directly. Inputs must be synchronous to `clk_i`, and latency drops by 2 cycles.

## Test plan
- Reset release, no events: `counter_o` reads 0, 1, 2… and `cap_valid_o` stays 0. Set `counter_clr_i` at `counter_o` = 100: the next value is 0.
- Channel 3 rising edge, sync enabled, event first sampled while `counter_o` = 50, `cap_ready_i` = 1: capture {ch 3, value 52, overrun 0}, valid for exactly 1 cycle.
- Channels 0, 4, 9 edge in the same cycle with ready held high: deliveries in order 0, 4, 9 on consecutive cycles, all with the same value.
- `cap_ready_i` = 0 and three rising edges on channel 2, with another channel's capture holding the output stage: the first timestamp is retained. On ready, channel 2 delivers its first value with `cap_overrun_o` = 1. The next channel-2 capture reports overrun 0.
- `edge_sel_i[5]` = 1 with a pulse on channel 5: only the falling edge produces a capture. With `capture_en_i[5]` = 0, no capture at all.
- Assert `rst_an_i` low with two captures pending and valid high: all outputs are 0 asynchronously, and nothing is delivered after reset release.
